// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore main control FSM for a multi-cycle MIPS-subset datapath.
//
// Sequences IF/ID/EX/MEM/WB and drives every datapath strobe.
// Ports:
//   clk         - system clock, FSM updates on rising edge
//   rst_n       - asynchronous active-low reset
//   instr       - instruction register output, opcode = instr[31:26]
//   zero        - ALU zero flag, consulted in BRANCH
//   mem_ready   - memory done; stalls IF / MEM_RD / MEM_WR while low
//   pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
//               - datapath control strobes and selects
//   state       - current state code (debug)
//   illegal     - sticky unknown-opcode flag
//   halted      - high while parked in HALT
//   instr_count - retired-instruction counter (wraps silently)
module multi_cycle_ctrl #(
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_EX_R    = 4'd2;
    localparam logic [3:0] S_MEMADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_MEM_WR  = 4'd5;
    localparam logic [3:0] S_WB_R    = 4'd6;
    localparam logic [3:0] S_WB_MEM  = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_EX_I    = 4'd10;
    localparam logic [3:0] S_WB_I    = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [5:0]       opcode;
    logic             unused_bits;

    assign opcode      = instr[31:26];
    assign unused_bits = ^instr[25:0];

    // The opcode is latched in ID so later states (MEMADDR, BRANCH) never
    // look at instr again; the IR may change freely outside ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_IF: state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                op_d = opcode;
                if (opcode == OP_R)
                    state_d = S_EX_R;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = S_MEMADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_d = S_BRANCH;
                else if (opcode == OP_J)
                    state_d = S_JUMP;
                else if (opcode == OP_ADDI)
                    state_d = S_EX_I;
                else if (opcode == HALT_OP)
                    state_d = S_HALT;
                else begin
                    state_d   = S_IF;
                    illegal_d = 1'b1;
                end
            end
            S_EX_R:    state_d = S_WB_R;
            S_MEMADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: begin
                state_d = mem_ready ? S_IF : S_MEM_WR;
                retire  = mem_ready;
            end
            S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_WB_I: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_EX_I: state_d = S_WB_I;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    // Outputs are gated by rst_n so strobes drop the instant reset asserts,
    // even though state_q itself already reads IF during reset.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        halted     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: alu_src_b = 2'b11;
                S_EX_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_MEMADDR, S_EX_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = (op_q == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                S_WB_I: reg_write = 1'b1;
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = rst_n ? state_q : 4'd0;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS-subset datapath; directly downstream of the instruction register, consuming its 32-bit output.
- Sequences IF/ID/EX/MEM/WB and drives every datapath strobe, including the IR write enable.
- The IR captures on the falling edge while ir_write is high, so the instruction written during IF is stable at the next rising edge (ID).

Parameters:
- CNT_W, 32, width of the retired-instruction counter
- HALT_OP, 6'h3F, opcode that parks the FSM in HALT

Ports:
- clk  in  1  system clock; FSM updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  IR output; opcode=instr[31:26]
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory done; stalls IF/MEM_RD/MEM_WR while 0
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state code, for debug
- illegal  out  1  sticky unknown-opcode flag
- halted  out  1  high in HALT
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state=IF(0), illegal=0, instr_count=0.
  - While rst_n is low, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0; all other outputs are 0.
- Outputs are a combinational function of state, plus mem_ready/zero where noted.
- Unlisted outputs are 0 in every state.
- States, outputs and transitions:
  - IF(0): mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready. Stays in IF while mem_ready=0, else goes to ID.
  - ID(1): alu_src_b=11 (branch target into ALUOut). Dispatch on opcode:
    - 000000 -> EX_R
    - 100011 / 101011 (lw/sw) -> MEMADDR
    - 000100 / 000101 (beq/bne) -> BRANCH
    - 000010 -> JUMP
    - 001000 (addi) -> EX_I
    - HALT_OP -> HALT
    - any other opcode -> IF with illegal set to 1 (sticky until reset); the instruction is not counted.
  - EX_R(2): alu_src_a=1, alu_op=10 -> WB_R.
  - MEMADDR(3): alu_src_a=1, alu_src_b=10 -> MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(4): mem_read=1, i_or_d=1. Waits for mem_ready, then -> WB_MEM.
  - MEM_WR(5): mem_write=1, i_or_d=1. Waits for mem_ready, then -> IF (retire).
  - WB_R(6): reg_write=1, reg_dst=1 -> IF (retire).
  - WB_MEM(7): reg_write=1, mem_to_reg=1 -> IF (retire).
  - BRANCH(8): alu_src_a=1, alu_op=01, pc_source=01; pc_write = zero for beq, ~zero for bne -> IF (retire).
  - JUMP(9): pc_source=10, pc_write=1 -> IF (retire).
  - EX_I(10): alu_src_a=1, alu_src_b=10 -> WB_I.
  - WB_I(11): reg_write=1 -> IF (retire).
  - HALT(12): halted=1, all strobes 0; remains in HALT until reset.
- Undefined state codes go to IF on the next edge.
- Cycle counts with mem_ready held high: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4. Each mem_ready=0 cycle adds 1.
- instr_count increments by 1 on every retire transition; it wraps to 0 past 2^CNT_W-1 with no flag.
- instr is sampled only in ID; changes in other states have no effect.
- Reset asserted mid-instruction aborts it: no partial strobes after the rst_n edge, and the count is not incremented.

Test Plan:
- Reset, then lw (instr=32'h8C080004) with mem_ready=1 -> state sequence 0,1,3,4,7,0; ir_write and pc_write high only in cycle 0; reg_write=1, mem_to_reg=1 in cycle 4; instr_count=1.
- beq (32'h11090002) with zero=1, then again with zero=0 -> first: 3 cycles, pc_write=1 and pc_source=01 in BRANCH; second: pc_write=0 in BRANCH; instr_count=2.
- sw with mem_ready low for 3 cycles in IF and 2 cycles in MEM_WR -> 9 cycles total; mem_write held high across the MEM_WR stall; ir_write only in the final IF cycle.
- opcode 6'h3E -> ID returns to IF; illegal=1 and stays 1 across a following valid add; instr_count counts only the add.
- instr=32'hFC000000 -> HALT (12), halted=1, all strobes 0 for 20 cycles; rst_n low -> state=0, halted=0, instr_count=0.
- rst_n pulsed low during MEM_RD -> mem_read drops immediately (asynchronous); the FSM restarts in IF; instr_count stays 0.
